// File: rtl/pattern_scheduler.sv
// pattern_scheduler: frame-synchronous test-pattern sequencer on the pixel clock.
// It keeps image_generator blank for a number of frame starts after reset, then steps
// through the test patterns, either automatically every DWELL_FRAMES or on request.
// Pattern changes are only ever applied on a frame start.
// Optional feature macro: PATTERN_SCHEDULER_DEBOUNCE_EN
//   defined   -> i_next is a raw button (2-flop synchronizer + DB_CYCLES debounce)
//   undefined -> i_next is a clean synchronous one-cycle pulse used directly
module pattern_scheduler #(
  parameter int NUM_PATTERNS   = 8,
  parameter int STARTUP_FRAMES = 4,
  parameter int DWELL_FRAMES   = 120,
  parameter bit VS_POL         = 1'b0,
  parameter int DB_CYCLES      = 16
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_vs,
  input  logic        i_auto,
  input  logic        i_next,
  output logic [3:0]  o_pattern,
  output logic        o_blank,
  output logic [15:0] o_frame,
  output logic [3:0]  o_led
);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam logic [3:0]  PATTERN_LAST = 4'(NUM_PATTERNS - 1);
  localparam logic [7:0]  STARTUP_LAST = 8'(STARTUP_FRAMES - 1);
  localparam logic [15:0] DWELL_LAST   = 16'(DWELL_FRAMES - 1);

  state_t      state;
  logic [7:0]  startup_cnt;
  logic [15:0] dwell_cnt;
  logic        pending;

  logic        vs_q;
  logic        vs_d;
  logic        vs_armed;
  logic        fs;
  logic        next_req;
  logic        advance;

  // Sync history for frame-start detection. vs_armed only sets once a genuinely
  // inactive sync has been sampled, so a sync already active at reset release
  // cannot be mistaken for a new frame start.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      vs_q     <= ~VS_POL;
      vs_d     <= ~VS_POL;
      vs_armed <= 1'b0;
    end else begin
      vs_q <= i_vs;
      vs_d <= vs_q;
      if (i_vs != VS_POL) begin
        vs_armed <= 1'b1;
      end
    end
  end

  assign fs = (vs_q == VS_POL) && (vs_d != VS_POL) && vs_armed;

`ifdef PATTERN_SCHEDULER_DEBOUNCE_EN
  localparam int DB_W = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  logic            next_sync1;
  logic            next_sync2;
  logic [DB_W-1:0] db_cnt;
  logic            db_level;
  logic            db_level_q;

  // Raw button: two-flop synchronizer, then the level only follows the input after
  // DB_CYCLES consecutive cycles of disagreement; shorter glitches are discarded.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      next_sync1 <= 1'b0;
      next_sync2 <= 1'b0;
      db_cnt     <= '0;
      db_level   <= 1'b0;
      db_level_q <= 1'b0;
    end else begin
      next_sync1 <= i_next;
      next_sync2 <= next_sync1;
      db_level_q <= db_level;
      if (next_sync2 == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_level <= next_sync2;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign next_req = db_level & ~db_level_q;
`else
  // DB_CYCLES only matters for the debounced build; this empty block just keeps it referenced.
  if (DB_CYCLES < 1) begin : g_db_cycles_unused
  end

  assign next_req = i_next;
`endif

  // A frame start advances on a latched request, a same-cycle request, or an expired dwell in auto mode.
  assign advance = pending | next_req | (i_auto & (dwell_cnt == DWELL_LAST));

  // Main sequencer: startup blanking, then pattern stepping applied only on frame starts.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state       <= ST_BLANK;
      o_pattern   <= 4'd0;
      o_blank     <= 1'b1;
      o_frame     <= 16'd0;
      startup_cnt <= 8'd0;
      dwell_cnt   <= 16'd0;
      pending     <= 1'b0;
    end else begin
      if (fs) begin
        o_frame <= o_frame + 16'd1;
      end
      case (state)
        ST_BLANK: begin
          o_blank <= 1'b1;
          if (fs) begin
            if (startup_cnt == STARTUP_LAST) begin
              state       <= ST_RUN;
              o_blank     <= 1'b0;
              dwell_cnt   <= 16'd0;
              startup_cnt <= 8'd0;
            end else begin
              startup_cnt <= startup_cnt + 8'd1;
            end
          end
        end
        ST_RUN: begin
          o_blank <= 1'b0;
          if (fs) begin
            pending <= 1'b0;
            if (advance) begin
              o_pattern <= (o_pattern == PATTERN_LAST) ? 4'd0 : o_pattern + 4'd1;
              dwell_cnt <= 16'd0;
            end else if (dwell_cnt != DWELL_LAST) begin
              dwell_cnt <= dwell_cnt + 16'd1;
            end
          end else if (next_req) begin
            pending <= 1'b1;
          end
        end
        default: begin
          state <= ST_BLANK;
        end
      endcase
    end
  end

  assign o_led = {(state == ST_RUN), pending, o_pattern[1:0]};

endmodule
